// File: rtl/aes_pkg.sv
// Shared types and GF(2^8) helpers for the AES-128 inverse key schedule.
package aes_pkg;

    localparam int         NR        = 10;
    localparam logic [7:0] RCON_INIT = 8'h01;
    localparam logic [7:0] RCON_LAST = 8'h36;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        OUTPUT = 2'd2
    } state_t;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    // Undo xtime: when the low bit is set the reduction polynomial was applied.
    function automatic logic [7:0] inv_xtime(input logic [7:0] x);
        return x[0] ? (((x ^ 8'h1b) >> 1) | 8'h80) : (x >> 1);
    endfunction

endpackage

// File: rtl/aes_subword.sv
// RotWord followed by four S-box lookups; purely combinational.
module aes_subword (
    input  logic [31:0] i_word,
    output logic [31:0] o_word
);
    // Byte 0x00 occupies the top 8 bits, byte 0xff the bottom 8 bits.
    localparam logic [2047:0] SBOX_FLAT = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic [31:0] w_rot;

    assign w_rot = {i_word[23:0], i_word[31:24]};

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        logic [7:0] w_idx;
        assign w_idx            = w_rot[8*g +: 8];
        assign o_word[8*g +: 8] = SBOX_FLAT[{~w_idx, 3'b000} +: 8];
    end

endmodule

// File: rtl/aes_inv_key_sched.sv
// AES-128 key schedule for decryption: expands forward to round 10, then
// steps the schedule backwards, presenting round keys 10 down to 0.
module aes_inv_key_sched
    import aes_pkg::*;
#(
    parameter int NR_ROUNDS = NR
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         key_load,
    input  logic [127:0] key_in,
    output logic         busy,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [127:0] rk_out,
    output logic [3:0]   rk_rnd
);
    localparam logic [3:0] RND_LAST = 4'(NR_ROUNDS);
    localparam logic [3:0] RND_HOLD = 4'(NR_ROUNDS - 1);

    state_t       r_state;
    state_t       w_state_nxt;
    logic [127:0] r_key;
    logic [3:0]   r_rnd;
    logic [7:0]   r_rcon;

    logic [31:0]  w_w0, w_w1, w_w2, w_w3;
    logic [31:0]  w_inv1, w_inv2, w_inv3, w_inv0;
    logic [31:0]  w_fwd0, w_fwd1, w_fwd2, w_fwd3;
    logic [31:0]  w_sub_in, w_sub, w_t;
    logic         w_out_st, w_hs;

    assign {w_w0, w_w1, w_w2, w_w3} = r_key;

    assign w_out_st = (r_state == OUTPUT);
    assign w_hs     = w_out_st && rk_ready;

    // Inverse step needs SubWord of the already-recovered w3, so the
    // single S-box stage is fed from either side of the mux.
    assign w_inv3   = w_w3 ^ w_w2;
    assign w_inv2   = w_w2 ^ w_w1;
    assign w_inv1   = w_w1 ^ w_w0;
    assign w_sub_in = w_out_st ? w_inv3 : w_w3;

    aes_subword u_subword (
        .i_word (w_sub_in),
        .o_word (w_sub)
    );

    assign w_t    = w_sub ^ {r_rcon, 24'h0};
    assign w_inv0 = w_w0 ^ w_t;
    assign w_fwd0 = w_w0 ^ w_t;
    assign w_fwd1 = w_w1 ^ w_fwd0;
    assign w_fwd2 = w_w2 ^ w_fwd1;
    assign w_fwd3 = w_w3 ^ w_fwd2;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (key_load) begin
            w_state_nxt = EXPAND;
        end else begin
            case (r_state)
                EXPAND:  if (r_rnd == RND_HOLD) w_state_nxt = OUTPUT;
                OUTPUT:  if (rk_ready && r_rnd == 4'd0) w_state_nxt = IDLE;
                default: w_state_nxt = r_state;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_key  <= '0;
            r_rnd  <= '0;
            r_rcon <= RCON_INIT;
        end else if (key_load) begin
            r_key  <= key_in;
            r_rnd  <= '0;
            r_rcon <= RCON_INIT;
        end else if (r_state == EXPAND) begin
            r_key  <= {w_fwd0, w_fwd1, w_fwd2, w_fwd3};
            r_rnd  <= r_rnd + 4'd1;
            // The last forward step and the first inverse step share rcon 0x36.
            r_rcon <= (r_rnd == RND_HOLD) ? RCON_LAST : xtime(r_rcon);
        end else if (w_hs && r_rnd != 4'd0) begin
            r_key  <= {w_inv0, w_inv1, w_inv2, w_inv3};
            r_rnd  <= r_rnd - 4'd1;
            r_rcon <= inv_xtime(r_rcon);
        end
    end

    assign busy     = (r_state == EXPAND);
    assign rk_valid = w_out_st && (r_rnd <= RND_LAST);
    assign rk_out   = r_key;
    assign rk_rnd   = r_rnd;

endmodule
